// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // System clocks per line bit, clock given in MHz.
    function automatic int unsigned calc_cycle(
        input int unsigned clk_mhz,
        input int unsigned baud
    );
        return (clk_mhz * 32'd1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CYCLE-1 while enabled, held at 0 otherwise.
// Ports: en_i count enable; mid_o strobe at count STROBE; end_o at CYCLE-1.
module uart_baud_gen #(
    parameter int unsigned CYCLE  = 5208,
    parameter int unsigned STROBE = 2603
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic en_i,
    output logic mid_o,
    output logic end_o
);

    localparam logic [15:0] LAST = 16'(CYCLE - 1);
    localparam logic [15:0] MID  = 16'(STROBE);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!en_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_o = en_i && (cnt_q == MID);
    assign end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver with valid/ready output, parity, framing and overrun flags.
// Ports: i_uart_rx serial in; o_data_rx/o_data_valid/i_data_ready word
// handshake; o_parity_err (qualified by valid); o_frame_err, o_overrun pulses.
// Define UART_RX_GLITCH_FILTER_EN for a 3-sample majority vote per bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int BAUD_RATE   = 9600
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data_rx,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun
);

    localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic        ODD = (PARITY_TYPE != 0);
    localparam logic        PAR_EN = (PARITY_ON != 0);

`ifdef UART_RX_GLITCH_FILTER_EN
    // One extra history flop so the vote sees counts CYCLE/2-2..CYCLE/2.
    localparam int          SYNC_W = 4;
    localparam int unsigned STROBE = CYCLE / 2;
`else
    localparam int          SYNC_W = 3;
    localparam int unsigned STROBE = CYCLE / 2 - 1;
`endif

    uart_state_t           state_q;
    logic [SYNC_W-1:0]     sync_q;
    logic [3:0]            bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  perr_q;
    logic                  ferr_q;
    logic                  ovr_q;

    logic fall;
    logic bit_v;
    logic smp;
    logic bend;

    // sync_q[0..1] form the synchronizer; higher bits are history.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_W-2:0], i_uart_rx};
        end
    end

    assign fall = sync_q[2] & ~sync_q[1];

`ifdef UART_RX_GLITCH_FILTER_EN
    assign bit_v = (sync_q[1] & sync_q[2]) |
                   (sync_q[1] & sync_q[3]) |
                   (sync_q[2] & sync_q[3]);
`else
    assign bit_v = sync_q[1];
`endif

    uart_baud_gen #(
        .CYCLE  (CYCLE),
        .STROBE (STROBE)
    ) u_baud (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .en_i      (state_q != ST_IDLE),
        .mid_o     (smp),
        .end_o     (bend)
    );

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && i_data_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (smp && bit_v) begin
                        state_q <= ST_IDLE;
                    end else if (bend) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (smp) begin
                        shift_q <= (shift_q >> 1) |
                                   (DATA_WIDTH'(bit_v) << (DATA_WIDTH - 1));
                    end
                    if (bend) begin
                        if (bit_q == LAST_BIT) begin
                            state_q <= PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    // par_q holds the error flag, not the parity bit.
                    if (smp) begin
                        par_q <= bit_v ^ (^shift_q) ^ ODD;
                    end
                    if (bend) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is seen.
                    if (smp) begin
                        state_q <= ST_IDLE;
                        if (!bit_v) begin
                            ferr_q <= 1'b1;
                        end else if (!valid_q || i_data_ready) begin
                            data_q  <= shift_q;
                            perr_q  <= par_q & PAR_EN;
                            valid_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_data_rx    = data_q;
    assign o_data_valid = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, corner sequences
// and random frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovr;

    int n_chk = 0;
    int n_fail = 0;
    int n_ferr = 0;
    int n_ovr = 0;

    uart_rx #(
        .CLK_FRE     (1),
        .DATA_WIDTH  (8),
        .PARITY_ON   (1),
        .PARITY_TYPE (0),
        .BAUD_RATE   (62500)
    ) dut (
        .i_clk_sys    (clk),
        .i_rst_n      (rst_n),
        .i_uart_rx    (rx),
        .o_data_rx    (data),
        .o_data_valid (valid),
        .i_data_ready (rdy),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_overrun    (ovr)
    );

    always #5 clk = ~clk;

    // Counting high cycles also exposes pulses that last too long.
    always @(negedge clk) begin
        if (ferr) n_ferr++;
        if (ovr) n_ovr++;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       ev;
        logic       ep;
        int         ef;
        string      nm;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic head(input logic [7:0] d, input logic p);
        hold(1'b0, CYC);
        for (int i = 0; i < 8; i++) hold(d[i], CYC);
        hold(p, CYC);
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic s);
        head(d, p);
        hold(s, CYC);
    endtask

    // Reference: even parity bit makes the count of ones even.
    function automatic logic even_par(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic run_frame(input string nm, input logic [7:0] d,
                             input logic p, input logic s,
                             input logic ev, input logic ep, input int ef);
        int f0;
        int o0;
        f0 = n_ferr;
        o0 = n_ovr;
        frame(d, p, s);
        hold(1'b1, 2 * CYC);
        chk({nm, " valid"}, valid, ev);
        if (ev) begin
            chk({nm, " data"}, data, d);
            chk({nm, " perr"}, perr, ep);
        end
        chk({nm, " ferr"}, n_ferr - f0, ef);
        chk({nm, " ovr"}, n_ovr - o0, 0);
        if (valid) begin
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
            chk({nm, " drain"}, valid, 0);
        end
    endtask

    initial begin
        int f0;
        int o0;
        logic [7:0] d;
        logic p;
        logic s;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 0, "a5_par1"};
        tbl[1] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 0, "a5_par0"};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, "3c_stop0"};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 0, "ff"};
        tbl[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 0, "01_bad"};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 0, "00_bad"};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 0, "80_ok"};

        repeat (3) @(negedge clk);
        chk("rst data", data, 0);
        chk("rst valid", valid, 0);
        chk("rst perr", perr, 0);
        chk("rst ferr", ferr, 0);
        chk("rst ovr", ovr, 0);
        rst_n = 1'b1;
        hold(1'b1, 2 * CYC);

        // 0xA5: valid must rise inside the stop bit, then drop on handshake.
        head(8'hA5, 1'b0);
        hold(1'b1, 4);
        chk("a5 early valid", valid, 0);
        hold(1'b1, CYC - 4);
        chk("a5 valid", valid, 1);
        chk("a5 data", data, 8'hA5);
        chk("a5 perr", perr, 0);
        hold(1'b1, 5);
        chk("a5 held", valid, 1);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("a5 cleared", valid, 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].nm, tbl[i].d, tbl[i].p, tbl[i].s,
                      tbl[i].ev, tbl[i].ep, tbl[i].ef);
        end

        // Short low glitch is a false start and leaves the line usable.
        f0 = n_ferr;
        o0 = n_ovr;
        hold(1'b0, 4);
        hold(1'b1, 3 * CYC);
        chk("glitch valid", valid, 0);
        chk("glitch ferr", n_ferr - f0, 0);
        chk("glitch ovr", n_ovr - o0, 0);
        run_frame("post_glitch", 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        // Back-to-back frames with no consumer: first kept, one overrun.
        o0 = n_ovr;
        f0 = n_ferr;
        frame(8'h11, 1'b0, 1'b1);
        frame(8'h22, 1'b0, 1'b1);
        hold(1'b1, 2 * CYC);
        chk("b2b valid", valid, 1);
        chk("b2b data", data, 8'h11);
        chk("b2b ovr", n_ovr - o0, 1);
        chk("b2b ferr", n_ferr - f0, 0);

        // Reset inside data bit 4 with a word still pending.
        hold(1'b0, CYC);
        for (int i = 0; i < 4; i++) hold(1'b1, CYC);
        hold(1'b1, CYC / 2);
        rst_n = 1'b0;
        #1;
        chk("mid rst data", data, 0);
        chk("mid rst valid", valid, 0);
        chk("mid rst perr", perr, 0);
        chk("mid rst ferr", ferr, 0);
        chk("mid rst ovr", ovr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, CYC);
        run_frame("after_rst", 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        for (int k = 0; k < 25; k++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rand%0d", k), d, p, s,
                      s, p ^ even_par(d), s ? 0 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning system clock frequency in MHz.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame (1..15).
REQ-003 SHALL have parameter PARITY_ON, default 0, meaning 1 = parity bit expected, 0 = none.
REQ-004 SHALL have parameter PARITY_TYPE, default 0, meaning 1 = odd parity, 0 = even parity.
REQ-005 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-006 SHALL have port i_clk_sys, input, 1 bit, meaning system clock.
REQ-007 SHALL have port i_rst_n, input, 1 bit, meaning asynchronous, active-low reset.
REQ-008 SHALL have port i_uart_rx, input, 1 bit, meaning asynchronous serial line, idle high.
REQ-009 SHALL have port o_data_rx, output, DATA_WIDTH bits, meaning received word, LSB first on the line.
REQ-010 SHALL have port o_data_valid, output, 1 bit, meaning o_data_rx holds an unconsumed word.
REQ-011 SHALL have port i_data_ready, input, 1 bit, meaning the consumer accepts the word.
REQ-012 SHALL have port o_parity_err, output, 1 bit, meaning the held word failed its parity check; qualified by o_data_valid.
REQ-013 SHALL have port o_frame_err, output, 1 bit, meaning a one-cycle pulse when a stop bit is sampled low.
REQ-014 SHALL have port o_overrun, output, 1 bit, meaning a one-cycle pulse when a frame completes while o_data_valid is still high.

Function
REQ-015 SHALL define CYCLE = CLK_FRE*1000000/BAUD_RATE and use a 16-bit baud counter that counts 0..CYCLE-1 and is held at 0 in IDLE.
REQ-016 SHALL pass i_uart_rx through a 2-flop synchronizer and detect the start condition as a synchronized 1->0 edge.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; transitions on a falling edge IDLE->START, then START->DATA, DATA->PARITY (PARITY_ON=1) or DATA->STOP after DATA_WIDTH bits, PARITY->STOP, STOP->IDLE.
REQ-018 SHALL sample each bit once, at baud count CYCLE/2-1 (mid-bit).
REQ-019 SHALL return to IDLE without any output activity if the start bit samples high (false start).
REQ-020 SHALL shift data in LSB first and compute parity as XOR of the data bits (XORed with 1 when PARITY_TYPE=1).
REQ-021 SHALL, on a high stop-bit sample with o_data_valid low, load o_data_rx and o_parity_err and set o_data_valid on the next clock edge (1-cycle latency after the stop sample).
REQ-022 SHALL, on a low stop-bit sample, discard the word, pulse o_frame_err, leave o_data_valid unchanged, and wait in IDLE for the line to be high before accepting a new falling edge.
REQ-023 SHALL clear o_data_valid on the cycle after i_data_ready && o_data_valid; o_data_rx SHALL stay stable while o_data_valid is high.
REQ-024 SHALL, on overrun, keep the old word, discard the new one, and pulse o_overrun; if ready handshakes in the same cycle as the stop sample, the new word SHALL be loaded and no overrun raised.
REQ-025 SHALL let the state machine enter STOP->IDLE at the stop-bit mid-sample so that back-to-back frames are received.

Reset
REQ-026 SHALL, on i_rst_n low at any time including mid-frame, asynchronously force IDLE, counters to 0, synchronizer flops to 1, o_data_rx to 0, and o_data_valid, o_parity_err, o_frame_err, o_overrun to 0.

Configuration
REQ-027 SHALL, when UART_RX_GLITCH_FILTER_EN is defined, decide each bit by majority vote of samples at counts CYCLE/2-2, CYCLE/2-1, CYCLE/2; when it is undefined, SHALL use the single sample of REQ-018.

Structure
REQ-028 SHALL place the state encodings and a CYCLE-computing function in package uart_pkg, which is shared with the transmitter.
REQ-029 SHALL instantiate sub-module uart_baud_gen, containing the counter and mid-bit strobe, reusable by the transmitter.

Verification (CLK_FRE=50, BAUD_RATE=9600, CYCLE=5208)
REQ-030 SHALL cover: frame 0xA5 with ready high -> o_data_rx=0xA5, o_data_valid high 1 cycle after the stop sample, then low after the handshake.
REQ-031 SHALL cover: PARITY_ON=1, even parity, 0xA5 with parity bit 1 -> o_data_valid=1, o_parity_err=1; with parity bit 0 -> o_parity_err=0.
REQ-032 SHALL cover: 0x3C with the stop bit driven 0 -> o_frame_err one-cycle pulse, o_data_valid stays 0.
REQ-033 SHALL cover: a 1000-cycle low glitch on an idle line -> no valid, no errors, FSM back in IDLE.
REQ-034 SHALL cover: frames 0x11 then 0x22 sent back-to-back with ready low -> o_data_rx=0x11 held, o_overrun pulses once.
REQ-035 SHALL cover: reset asserted at DATA bit 4 -> all outputs 0; the next 0x5A frame is received correctly.
